fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR controller that sequences a single multiply-accumulate unit over all filter taps for each accepted sample. It holds the sample delay line and a runtime-writable coefficient bank. It sits between the sample source and the consumer of the filtered output `yn`, replacing a fully parallel FIR when area matters more than throughput. It produces one output per `TAPS + 2` cycles.

---
 rtl/fir_mac_sequencer_pkg.sv | 10 +
 rtl/fir_mac_sequencer_if.sv | 17 +
 rtl/fir_mac_sequencer_mac_unit.sv | 18 +
 rtl/fir_mac_sequencer.sv | 67 ++++++
 tb/tb_fir_mac_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// fir_ctrl_pkg: shared FSM states, reset constants and product sign-extension helper
package fir_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  localparam int COEF_RESET = 1;
  function automatic logic signed [63:0] sext(input logic [63:0] p, input int pw);
    logic signed [63:0] t;
    t = p << (64 - pw);
    return t >>> (64 - pw);
  endfunction
endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample, output and coefficient-write signals of the FIR controller
interface fir_mac_sequencer_if #(parameter int TAPS = 4, DW = 16, CW = 16, AW = 32);
  logic in_valid;
  logic in_ready;
  logic signed [DW-1:0] xn;
  logic out_valid;
  logic signed [AW-1:0] yn;
  logic busy;
  logic coef_we;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic coef_drop;
  modport master (output in_valid, xn, coef_we, coef_addr, coef_data,
                  input in_ready, out_valid, yn, busy, coef_drop);
  modport slave (input in_valid, xn, coef_we, coef_addr, coef_data,
                 output in_ready, out_valid, yn, busy, coef_drop);
endinterface

// File: rtl/fir_mac_sequencer_mac_unit.sv
// fir_mac_unit: signed multiplier feeding a wrapping accumulator with clear and enable
module fir_mac_unit import fir_ctrl_pkg::*; #(parameter int DW = 16, CW = 16, AW = 32) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc
);
  logic signed [DW+CW-1:0] prod;
  assign prod = a * b;
  // accumulate the full-width product, wrapping modulo 2^AW
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + AW'(sext(64'(prod), DW + CW));
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR sequencing one MAC over all taps per sample
module fir_mac_sequencer import fir_ctrl_pkg::*; #(parameter int TAPS = 4, DW = 16, CW = 16, AW = 32) (
  input logic clk,
  input logic reset_n,
  fir_mac_sequencer_if.slave bus
);
  localparam int KW = $clog2(TAPS);
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic signed [DW-1:0] d [TAPS];
  logic signed [CW-1:0] c [TAPS];
  logic signed [AW-1:0] acc;
  logic hs, wr_ok, last;
  assign hs = bus.in_valid && bus.in_ready;
  assign wr_ok = bus.coef_we && (int'(bus.coef_addr) < TAPS);
  assign last = k == KW'(TAPS - 1);
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  // next state: accept in IDLE, walk taps in MAC, publish in DONE
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (hs ? MAC : IDLE) : state == MAC ? (last ? DONE : MAC) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // tap counter restarts on every accepted sample
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) k <= '0;
    else if (hs) k <= '0;
    else if (state == MAC) k <= k + KW'(1);
  // delay line shifts on acceptance; coefficient bank writable only while idle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        c[i] <= CW'(COEF_RESET);
      end
    end else begin
      if (hs) begin
        d[0] <= bus.xn;
        for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
      end
      if (wr_ok && state == IDLE) c[bus.coef_addr] <= bus.coef_data;
    end
  // registered outputs: result pulse and rejected-write pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.yn <= '0;
      bus.out_valid <= 1'b0;
      bus.coef_drop <= 1'b0;
    end else begin
      bus.out_valid <= state == DONE;
      if (state == DONE) bus.yn <= acc;
      bus.coef_drop <= wr_ok && state != IDLE;
    end
  fir_mac_unit #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .clk(clk),
    .reset_n(reset_n),
    .clr(hs),
    .en(state == MAC),
    .a(d[k]),
    .b(c[k]),
    .acc(acc)
  );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vectors with hand-computed results for the FIR controller
module tb_fir_mac_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt = 0;
  always #5 clk = ~clk;
  fir_mac_sequencer_if #(.TAPS(4), .DW(16), .CW(16), .AW(32)) bus();
  fir_mac_sequencer #(.TAPS(4), .DW(16), .CW(16), .AW(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always @(negedge clk) if (bus.out_valid) ov_cnt++;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    bus.in_valid = 0;
    bus.xn = 0;
    bus.coef_we = 0;
    bus.coef_addr = 0;
    bus.coef_data = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask
  task automatic wr_coef(input logic [1:0] a, input logic signed [15:0] v);
    bus.coef_we = 1;
    bus.coef_addr = a;
    bus.coef_data = v;
    @(posedge clk);
    #1 bus.coef_we = 0;
  endtask
  task automatic push(input logic signed [15:0] x, input logic we, input logic [1:0] a,
                      input logic signed [15:0] v, output logic signed [31:0] y, output int lat);
    int n;
    bus.xn = x;
    bus.in_valid = 1;
    bus.coef_we = we;
    bus.coef_addr = a;
    bus.coef_data = v;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 0;
    bus.coef_we = 0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    y = bus.yn;
  endtask
  task automatic sample(input string tag, input logic signed [15:0] x, input logic signed [31:0] e);
    logic signed [31:0] y;
    int lat;
    push(x, 0, 0, 0, y, lat);
    chk({tag, "_y"}, y, e);
    chk({tag, "_lat"}, lat, 5);
  endtask
  initial begin
    int hs [3];
    int ov [3];
    logic signed [31:0] ys [3];
    logic signed [15:0] samp [3];
    logic signed [31:0] y;
    int nh, no, low, base, n;
    do_reset();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_coef_drop", bus.coef_drop, 0);
    chk("rst_yn", bus.yn, 0);
    samp[0] = 10; samp[1] = 20; samp[2] = 30;
    for (int i = 0; i < 3; i++) begin hs[i] = -100; ov[i] = -1; ys[i] = 0; end
    nh = 0; no = 0; low = 0;
    bus.xn = samp[0];
    bus.in_valid = 1;
    for (int i = 0; i < 40 && no < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin ov[no] = i; ys[no] = bus.yn; no++; end
      if (nh > 0 && hs[nh-1] == i - 1) begin
        if (nh == 3) bus.in_valid = 0;
        else bus.xn = samp[nh];
      end
      if (!bus.in_ready) low++;
      else if (bus.in_valid) begin hs[nh] = i; nh++; end
    end
    bus.in_valid = 0;
    chk("cont_handshakes", nh, 3);
    chk("cont_outputs", no, 3);
    chk("cont_gap01", hs[1] - hs[0], 6);
    chk("cont_gap12", hs[2] - hs[1], 6);
    for (int i = 0; i < 3; i++) chk($sformatf("cont_lat%0d", i), ov[i] - hs[i], 6);
    chk("cont_ready_low", low, 15);
    chk("cont_y0", ys[0], 10);
    chk("cont_y1", ys[1], 30);
    chk("cont_y2", ys[2], 60);
    do_reset();
    chk("rst2_yn", bus.yn, 0);
    base = ov_cnt;
    sample("ramp0", 100, 100);
    sample("ramp1", 200, 300);
    sample("ramp2", 300, 600);
    sample("ramp3", 400, 1000);
    sample("ramp4", 0, 900);
    repeat (2) @(negedge clk);
    chk("ramp_pulses", ov_cnt - base, 5);
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(2'(i), 16'(i + 1));
    chk("idle_wr_no_drop", bus.coef_drop, 0);
    sample("imp0", 1, 1);
    sample("imp1", 0, 2);
    sample("imp2", 0, 3);
    sample("imp3", 0, 4);
    bus.xn = 0;
    bus.in_valid = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    chk("mac_busy", bus.busy, 1);
    chk("mac_in_ready", bus.in_ready, 0);
    bus.coef_we = 1;
    bus.coef_addr = 2;
    bus.coef_data = 7;
    @(posedge clk);
    #1 bus.coef_we = 0;
    chk("drop_pulse", bus.coef_drop, 1);
    @(posedge clk);
    #1 chk("drop_once", bus.coef_drop, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drop_lat", n, 3);
    chk("drop_y", bus.yn, 0);
    sample("tap2_a", 1, 1);
    sample("tap2_b", 0, 2);
    sample("tap2_c", 0, 3);
    push(2, 1, 0, 5, y, n);
    chk("hs_wr_y", y, 14);
    chk("hs_wr_lat", n, 5);
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(2'(i), 32767);
    sample("ovf0", -32768, -1073709056);
    sample("ovf1", -32768, -2147418112);
    sample("ovf2", -32768, 1073840128);
    sample("ovf3", -32768, 131072);
    bus.xn = 9;
    bus.in_valid = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    @(posedge clk);
    #1 reset_n = 0;
    base = ov_cnt;
    #1 chk("abort_yn", bus.yn, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (8) @(posedge clk);
    #1 chk("abort_no_pulse", ov_cnt - base, 0);
    chk("abort_yn_held", bus.yn, 0);
    sample("post_abort", 50, 50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
